hex_display_mux: RTL and testbench

- Parametrised successor to the single-digit hex-to-7-segment converter.
- Drives NUM_DIGITS common-anode 7-segment digits from one shared active-low segment bus by time-multiplexing, with one digit enabled at a time.
- Holds the value in a load-strobed shadow register, and supports per-digit blanking and optional leading-zero suppression.
- Sits between datapath or lab logic and the board's digit and segment pins.

---
 rtl/hex_display_mux.sv | 115 +++++++++++
 tb/tb_hex_display_mux.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver: a load-strobed shadow register scanned onto
// NUM_DIGITS common-anode digits with per-digit blanking and leading-zero suppression.
module hex_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    lz_suppress,
   output logic [0:6]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        digit_idx
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   // Segment pattern for one nibble, active-low, written in the board's table order
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0:    hex7 = 7'b100_0000;
         4'h1:    hex7 = 7'b111_1001;
         4'h2:    hex7 = 7'b010_0100;
         4'h3:    hex7 = 7'b011_0000;
         4'h4:    hex7 = 7'b001_1001;
         4'h5:    hex7 = 7'b001_0010;
         4'h6:    hex7 = 7'b000_0010;
         4'h7:    hex7 = 7'b111_1000;
         4'h8:    hex7 = 7'b000_0000;
         4'h9:    hex7 = 7'b001_1000;
         4'hA:    hex7 = 7'b000_1000;
         4'hB:    hex7 = 7'b000_0011;
         4'hC:    hex7 = 7'b100_0110;
         4'hD:    hex7 = 7'b010_0001;
         4'hE:    hex7 = 7'b000_0110;
         4'hF:    hex7 = 7'b000_1110;
         default: hex7 = 7'b111_1111;
      endcase
   endfunction

   logic [4*NUM_DIGITS-1:0] shadow_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;

   logic [3:0]              nibble_s;
   logic [NUM_DIGITS-1:0]   lz_blank_s;
   logic [NUM_DIGITS-1:0]   an_s;
   logic                    zero_run_s;
   logic                    blank_s;

   // Shadow register: display content only changes on a load strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_r <= '0;
      end else if (load) begin
         shadow_r <= value;
      end
   end

   // Refresh counter and scan index
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
         idx_r <= '0;
      end else if (cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_r <= '0;
         idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Leading-zero map: a digit is suppressible while it and everything above it is zero
   always_comb begin
      lz_blank_s = '0;
      zero_run_s = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run_s    = zero_run_s & (shadow_r[4*i +: 4] == 4'h0);
         lz_blank_s[i] = zero_run_s;
      end
   end

   // Select the current digit's nibble, enable pattern and blank decision
   always_comb begin
      nibble_s = 4'h0;
      blank_s  = 1'b0;
      an_s     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_r == IDX_W'(i)) begin
            nibble_s = shadow_r[4*i +: 4];
            blank_s  = blank_mask[i] | (lz_suppress & lz_blank_s[i]);
            an_s[i]  = 1'b0;
         end else begin
            an_s[i]  = 1'b1;
         end
      end
   end

   // Registered outputs, one cycle behind the scan state
   always_ff @(posedge clk) begin
      if (reset) begin
         seg       <= 7'b111_1111;
         an        <= '1;
         digit_idx <= '0;
      end else begin
         seg       <= blank_s ? 7'b111_1111 : hex7(nibble_s);
         an        <= an_s;
         digit_idx <= idx_r;
      end
   end

endmodule

// File: tb/tb_hex_display_mux.sv
// Randomized/directed bench for hex_display_mux against an arithmetic reference model.
module tb_hex_display_mux;

   localparam int ND = 4;
   localparam int RD = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [15:0]   value = 16'h0000;
   logic [3:0]    blank_mask = 4'b0000;
   logic          lz_suppress = 1'b0;
   logic [0:6]    seg;
   logic [3:0]    an;
   logic [1:0]    digit_idx;

   int errors = 0;
   int checks = 0;

   logic [6:0] segtab [16] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                               7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                               7'b000_0000, 7'b001_1000, 7'b000_1000, 7'b000_0011,
                               7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110};

   int m_shadow = 0;
   int m_cnt = 0;
   int m_idx = 0;

   hex_display_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk(clk), .reset(reset), .load(load), .value(value),
      .blank_mask(blank_mask), .lz_suppress(lz_suppress),
      .seg(seg), .an(an), .digit_idx(digit_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict outputs from pre-edge model state, advance model, compare
   task automatic tick();
      logic [6:0] e_seg;
      logic [3:0] e_an;
      int         e_idx;
      int         above;
      bit         blk;
      if (reset) begin
         e_seg = 7'b111_1111;
         e_an  = 4'b1111;
         e_idx = 0;
      end else begin
         above = m_shadow >> (4 * m_idx);
         blk   = blank_mask[m_idx] || (lz_suppress && m_idx > 0 && above == 0);
         e_seg = blk ? 7'b111_1111 : segtab[above & 15];
         e_an  = 4'b1111 & ~(4'b0001 << m_idx);
         e_idx = m_idx;
      end
      if (reset) begin
         m_shadow = 0;
         m_cnt    = 0;
         m_idx    = 0;
      end else begin
         if (load) m_shadow = int'(value);
         if (m_cnt == RD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % ND;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("digit_idx", 32'(digit_idx), 32'(e_idx));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_load(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   initial begin
      int n;
      logic [15:0] v;

      // Reset held for three cycles
      reset = 1'b1;
      run(3);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      reset = 1'b0;
      tick();
      chk("first_an", 32'(an), 32'b1110);
      chk("first_idx", 32'(digit_idx), 32'd0);

      // Basic scan of 1A3F
      do_load(16'h1A3F);
      run(17);

      // Leading-zero suppression
      lz_suppress = 1'b1;
      do_load(16'h0040);
      run(16);
      do_load(16'h0000);
      run(16);
      lz_suppress = 1'b0;

      // Mask blanking, cleared mid-dwell
      blank_mask = 4'b0101;
      do_load(16'h8888);
      run(10);
      blank_mask = 4'b0000;
      run(6);

      // Value change without load must not show
      value = 16'hFFFF;
      run(16);

      // Load on the same edge as an index wrap
      n = 0;
      while (!(m_cnt == RD - 1 && m_idx == ND - 1) && n < 40) begin
         tick();
         n++;
      end
      chk("wrap_sync", 32'(n < 40), 32'd1);
      do_load(16'h5C2E);
      run(8);

      // Every nibble value on digit 0
      for (int d = 0; d < 16; d++) begin
         do_load(16'(d));
         run(16);
      end

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         load        = ($urandom_range(0, 7) == 0);
         value       = 16'($urandom);
         blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         lz_suppress = 1'($urandom);
         reset       = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 3) == 0) begin
            v     = 16'($urandom_range(0, 255));
            value = v;
         end
         tick();
      end
      reset = 1'b0;
      load = 1'b0;
      blank_mask = 4'b0000;
      lz_suppress = 1'b0;
      do_load(16'h7654);

      // Reset mid-dwell on digit 2
      n = 0;
      while (!(m_idx == 2 && m_cnt == 1) && n < 40) begin
         tick();
         n++;
      end
      chk("dwell_sync", 32'(n < 40), 32'd1);
      reset = 1'b1;
      tick();
      chk("mid_rst_seg", 32'(seg), 32'h7F);
      chk("mid_rst_an", 32'(an), 32'hF);
      reset = 1'b0;
      tick();
      chk("restart_an", 32'(an), 32'b1110);
      chk("restart_seg", 32'(seg), 32'b100_0000);
      run(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
